// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer
// Reader side of a shared tri-state data bus. One read request at a time.
// Each request gets a one-cycle turnaround gap with every enable low. The
// named driver is then enabled for SETTLE cycles. The bus is sampled at the
// end of the last enabled cycle, and the word is returned over a valid/ready
// handshake. This block is the only one that raises drive enables, so at
// most one driver is ever on.
module bus_read_sequencer #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SRC_W-1:0]   req_src,
  input  logic [WIDTH-1:0]   bus_in,
  output logic [NUM_SRC-1:0] drive_en,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_err
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    DRIVE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [SRC_W-1:0]   src_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               src_bad_s;

  // Build the one-hot enable for a source index. Only indices below NUM_SRC
  // can set a bit, so an out-of-range index yields all zeros.
  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] s);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      oh[i] = (s == SRC_W'(i));
    end
    return oh;
  endfunction

  // An extra leading bit keeps the compare valid when NUM_SRC == 2**SRC_W.
  assign src_bad_s = ({1'b0, req_src} >= (SRC_W + 1)'(NUM_SRC));

  // req_ready is a pure state decode, so it is high in IDLE, including during reset.
  assign req_ready = (state_r == IDLE);

  // Sequencer FSM. All outputs are registered. Reset wins over every other action.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      src_r    <= '0;
      cnt_r    <= '0;
      drive_en <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            src_r <= req_src;
            if (src_bad_s) begin
              // Nonexistent source: never enable anything, report the error at once.
              state_r  <= DONE;
              rd_valid <= 1'b1;
              rd_err   <= 1'b1;
              rd_data  <= '0;
            end else begin
              state_r <= TURN;
            end
          end
        end
        TURN: begin
          // Bus turnaround gap is this cycle. The enable rises for the next one.
          drive_en <= src_onehot(src_r);
          cnt_r    <= CNT_W'(SETTLE - 1);
          state_r  <= DRIVE;
        end
        DRIVE: begin
          if (cnt_r == CNT_W'(0)) begin
            rd_data  <= bus_in;
            rd_err   <= 1'b0;
            rd_valid <= 1'b1;
            drive_en <= '0;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          drive_en <= '0;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
